// File: rtl/sph_pkg.sv
// rtl/sph_pkg.sv - shared sphere widths, scale constants and state enum
package sph_pkg;

    // Datapath widths shared by the forward (radius->area) and inverse blocks.
    localparam int AREA_W  = 26;
    localparam int RAD_W   = 16;
    localparam int K_W     = 13;
    localparam int K_SHIFT = 16;

    // round(2^K_SHIFT / (4*pi))
    localparam logic [K_W-1:0] K_INV4PI = 13'd5215;

    // Scaled value q = (area * K_INV4PI) >> K_SHIFT and its square-root geometry.
    localparam int PROD_W  = AREA_W + K_W;
    localparam int Q_W     = PROD_W - K_SHIFT;
    localparam int ROOT_IT = (Q_W + 1) / 2;
    localparam int QP_W    = 2 * ROOT_IT;
    localparam int REM_W   = ROOT_IT + 2;
    localparam int IT_W    = $clog2(ROOT_IT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCALE = 2'd1,
        ROOT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/isqrt_iter.sv
// rtl/isqrt_iter.sv - one combinational bit-pair step of the integer square root
module isqrt_iter
    import sph_pkg::*;
(
    input  logic [REM_W-1:0]   i_rem,
    input  logic [ROOT_IT-1:0] i_root,
    input  logic [1:0]         i_q2,
    output logic [REM_W-1:0]   o_rem,
    output logic [ROOT_IT-1:0] o_root
);

    // One spare top bit so a borrow shows up as a set sign bit.
    logic [REM_W+2:0] w_dividend;
    logic [REM_W+2:0] w_divisor;
    logic [REM_W+2:0] w_trial;
    logic             w_neg;
    logic             w_unused;

    assign w_dividend = {1'b0, i_rem, i_q2};
    assign w_divisor  = {3'b000, i_root, 2'b01};
    assign w_trial    = w_dividend - w_divisor;
    assign w_neg      = w_trial[REM_W+2];

    // The remainder never exceeds 2*root, so the low REM_W bits always hold it;
    // on a failed trial the shifted-in dividend is kept (restoring step).
    assign o_rem  = w_neg ? w_dividend[REM_W-1:0] : w_trial[REM_W-1:0];
    assign o_root = {i_root[ROOT_IT-2:0], ~w_neg};

    assign w_unused = ^{w_trial[REM_W+1:REM_W], w_dividend[REM_W+2:REM_W], i_root[ROOT_IT-1]};

endmodule

// File: rtl/area_to_radius.sv
// rtl/area_to_radius.sv - radius = sqrt(area/(4*pi)); AREA_TO_RADIUS_ROUND_EN selects round-to-nearest
module area_to_radius
    import sph_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [AREA_W-1:0] area,
    output logic [RAD_W-1:0]  radius,
    output logic              rdy,
    output logic              busy
);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_load;
    logic               w_step;
    logic               w_finish;

    logic [AREA_W-1:0]  r_area;
    logic [QP_W-1:0]    r_q;
    logic [REM_W-1:0]   r_rem;
    logic [ROOT_IT-1:0] r_root;
    logic [IT_W-1:0]    r_it;
    logic [RAD_W-1:0]   r_radius;
    logic               r_rdy;
    logic               r_busy;

    logic [PROD_W-1:0]  w_prod;
    logic [Q_W-1:0]     w_q;
    logic [1:0]         w_q2;
    logic [REM_W-1:0]   w_rem_nxt;
    logic [ROOT_IT-1:0] w_root_nxt;
    logic [RAD_W-1:0]   w_result;
    logic               w_unused;

    // Full-width product, then drop the fraction bits of the 1/(4*pi) scale.
    assign w_prod   = PROD_W'(r_area) * PROD_W'(K_INV4PI);
    assign w_q      = w_prod[PROD_W-1:K_SHIFT];
    assign w_unused = ^w_prod[K_SHIFT-1:0];

    // Bit pair consumed this iteration, most significant pair first.
    assign w_q2 = r_q[{r_it, 1'b0} +: 2];

    isqrt_iter u_isqrt_iter (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_q2   (w_q2),
        .o_rem  (w_rem_nxt),
        .o_root (w_root_nxt)
    );

`ifdef AREA_TO_RADIUS_ROUND_EN
    logic w_round_up;
    // rem > root means q is past (root + 0.5)^2, so the nearest integer is root+1.
    assign w_round_up = (r_rem > REM_W'(r_root));
    assign w_result   = RAD_W'(r_root) + (w_round_up ? RAD_W'(1) : RAD_W'(0));
`else
    assign w_result = RAD_W'(r_root);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_accept     = 1'b1;
                    w_next_state = SCALE;
                end
            end
            SCALE: begin
                w_load       = 1'b1;
                w_next_state = ROOT;
            end
            ROOT: begin
                w_step = 1'b1;
                if (r_it == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_finish     = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture, scaling and square-root iteration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_area <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_it   <= '0;
        end else begin
            if (w_accept) begin
                r_area <= area;
            end
            if (w_load) begin
                r_q    <= QP_W'(w_q);
                r_rem  <= '0;
                r_root <= '0;
                r_it   <= IT_W'(ROOT_IT - 1);
            end
            if (w_step) begin
                r_rem  <= w_rem_nxt;
                r_root <= w_root_nxt;
                if (r_it != '0) begin
                    r_it <= r_it - IT_W'(1);
                end
            end
        end
    end

    // Result, completion pulse and busy flag (busy spans the rdy cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_radius <= '0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy  <= w_finish;
            r_busy <= (w_next_state != IDLE) || w_finish;
            if (w_finish) begin
                r_radius <= w_result;
            end
        end
    end

    assign radius = r_radius;
    assign rdy    = r_rdy;
    assign busy   = r_busy;

endmodule

// File: tb/tb_area_to_radius.sv
// tb/tb_area_to_radius.sv - scoreboard bench for area_to_radius
module tb_area_to_radius;

    logic        clk;
    logic        rst;
    logic        en;
    logic [25:0] area;
    logic [15:0] radius;
    logic        rdy;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] rad;
        int          rdy_cyc;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    area_to_radius dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .area   (area),
        .radius (radius),
        .rdy    (rdy),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [25:0] a);
        longint q;
        longint r;
        q = (longint'(a) * 64'd5215) >> 16;
        r = 0;
        while ((r + 1) * (r + 1) <= q) r++;
`ifdef AREA_TO_RADIUS_ROUND_EN
        if (q - r * r > r) r++;
`endif
        return 16'(r);
    endfunction

    // Result monitor: every rdy pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_radius"}, 32'(radius), 32'(e.rad));
                check({e.tag, "_latency"}, 32'(cyc), 32'(e.rdy_cyc));
                check({e.tag, "_busy"}, 32'(busy), 32'd1);
                check({e.tag, "_upper"}, 32'(radius[15:13]), 32'd0);
            end
        end
    end

    task automatic push(input string tag, input logic [25:0] a, input int rc);
        exp_t e;
        e.rad     = model(a);
        e.rdy_cyc = rc;
        e.tag     = tag;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Single request; area is scrambled after the accepting edge.
    task automatic run_one(input string tag, input logic [25:0] a, input bit poke_en);
        wait_idle();
        area = a;
        en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        push(tag, a, cyc + 14);
        en   = 1'b0;
        area = 26'($urandom);
        if (poke_en) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                en = ~en;
            end
            en = 1'b0;
        end
        drain();
    endtask

    initial begin
        logic [25:0] seq [3];
        int n0;
        seq[0] = 26'd12566371;
        seq[1] = 26'd12566;
        seq[2] = 26'd0;

        rst  = 1'b1;
        en   = 1'b0;
        area = '0;
        #1;
        check("reset_out", {13'd0, radius, rdy, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_out", {13'd0, radius, rdy, busy}, 32'd0);
        end

        run_one("a1000",  26'd12566371, 1'b0);
        run_one("a31",    26'd12566,    1'b1);
        run_one("a0",     26'd0,        1'b0);
        run_one("amax",   26'd67108863, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_one("rand", 26'($urandom), 1'b0);
        end

        // Back-to-back with en held high.
        wait_idle();
        area = seq[0];
        en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n0 = cyc;
        push("b2b0", seq[0], n0 + 14);
        area = seq[1];
        push("b2b1", seq[1], n0 + 29);
        repeat (15) @(negedge clk);
        area = seq[2];
        push("b2b2", seq[2], n0 + 44);
        repeat (15) @(negedge clk);
        en   = 1'b0;
        area = 26'($urandom);
        drain();

        // Reset mid-operation, after a nonzero result is on radius.
        run_one("pre_rst", 26'd67108863, 1'b0);
        area = 26'd12566371;
        en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out", {13'd0, radius, rdy, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_idle", {13'd0, radius, rdy, busy}, 32'd0);
        end
        run_one("restart", 26'd12566371, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
